// File: rtl/msrv32_wb_load_unit.sv
// Stage-3 write-back select and load unit: registers the register-file write,
// running a request/acknowledge data-memory read (with pipeline stall) for loads.
module msrv32_wb_load_unit (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        valid_in,
    input  logic [4:0]  rd_addr_reg_in,
    input  logic        rf_wr_en_reg_in,
    input  logic [2:0]  wb_mux_sel_reg_in,
    input  logic [1:0]  load_size_reg_in,
    input  logic        load_unsigned_reg_in,
    input  logic [31:0] iadder_out_reg_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] imm_reg_in,
    input  logic [31:0] pc_plus_4_reg_in,
    input  logic [31:0] csr_data_in,
    output logic        dmem_rd_req_out,
    output logic [31:0] dmem_addr_out,
    input  logic [31:0] dmem_rdata_in,
    input  logic        dmem_ack_in,
    output logic        stall_out,
    output logic        rf_wr_en_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_data_out,
    output logic        misaligned_load_out
);

    // Handshake: dmem_rd_req_out stays high with a stable dmem_addr_out until a
    // rising edge samples dmem_ack_in=1; dmem_rdata_in is taken on that edge.
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_uns_q, ld_uns_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        dmem_rd_req_q, dmem_rd_req_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic        rf_wr_en_q, rf_wr_en_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        misaligned_q, misaligned_d;

    logic        is_load, misaligned, aligned_load;
    logic [31:0] wb_sel_data, load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign is_load      = valid_in & rf_wr_en_reg_in & (wb_mux_sel_reg_in == 3'b001);
    assign misaligned   = ((load_size_reg_in == 2'b01) & iadder_out_reg_in[0]) |
                          (load_size_reg_in[1] & (iadder_out_reg_in[1:0] != 2'b00));
    assign aligned_load = is_load & ~misaligned;

    always_comb begin
        case (wb_mux_sel_reg_in)
            3'b010:  wb_sel_data = imm_reg_in;
            3'b011:  wb_sel_data = iadder_out_reg_in;
            3'b100:  wb_sel_data = csr_data_in;
            3'b101:  wb_sel_data = pc_plus_4_reg_in;
            default: wb_sel_data = alu_result_in;
        endcase
    end

    always_comb begin
        case (ld_off_q)
            2'd1:    ld_byte = dmem_rdata_in[15:8];
            2'd2:    ld_byte = dmem_rdata_in[23:16];
            2'd3:    ld_byte = dmem_rdata_in[31:24];
            default: ld_byte = dmem_rdata_in[7:0];
        endcase
        ld_half = ld_off_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (ld_size_q)
            2'b00:   load_data = {{24{~ld_uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~ld_uns_q & ld_half[15]}}, ld_half};
            default: load_data = dmem_rdata_in;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        ld_rd_d       = ld_rd_q;
        ld_size_d     = ld_size_q;
        ld_uns_d      = ld_uns_q;
        ld_off_d      = ld_off_q;
        dmem_rd_req_d = dmem_rd_req_q;
        dmem_addr_d   = dmem_addr_q;
        rf_wr_en_d    = 1'b0;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        misaligned_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_load) begin
                    ld_rd_d       = rd_addr_reg_in;
                    ld_size_d     = load_size_reg_in;
                    ld_uns_d      = load_unsigned_reg_in;
                    ld_off_d      = iadder_out_reg_in[1:0];
                    dmem_rd_req_d = 1'b1;
                    dmem_addr_d   = {iadder_out_reg_in[31:2], 2'b00};
                    state_d       = WAIT;
                end else if (is_load) begin
                    misaligned_d = 1'b1;
                end else if (valid_in) begin
                    rf_wr_en_d = rf_wr_en_reg_in & (rd_addr_reg_in != 5'd0);
                    rd_addr_d  = rd_addr_reg_in;
                    rd_data_d  = wb_sel_data;
                end
            end
            WAIT: begin
                // A load to x0 still completes the read but suppresses the write.
                if (dmem_ack_in) begin
                    dmem_rd_req_d = 1'b0;
                    rf_wr_en_d    = (ld_rd_q != 5'd0);
                    rd_addr_d     = ld_rd_q;
                    rd_data_d     = load_data;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= IDLE;
            ld_rd_q       <= 5'd0;
            ld_size_q     <= 2'd0;
            ld_uns_q      <= 1'b0;
            ld_off_q      <= 2'd0;
            dmem_rd_req_q <= 1'b0;
            dmem_addr_q   <= 32'd0;
            rf_wr_en_q    <= 1'b0;
            rd_addr_q     <= 5'd0;
            rd_data_q     <= 32'd0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ld_rd_q       <= ld_rd_d;
            ld_size_q     <= ld_size_d;
            ld_uns_q      <= ld_uns_d;
            ld_off_q      <= ld_off_d;
            dmem_rd_req_q <= dmem_rd_req_d;
            dmem_addr_q   <= dmem_addr_d;
            rf_wr_en_q    <= rf_wr_en_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // Reset also forces the stall low so upstream is released immediately.
    assign stall_out           = ~reset_in & (((state_q == IDLE) & aligned_load) | (state_q == WAIT));
    assign dmem_rd_req_out     = dmem_rd_req_q;
    assign dmem_addr_out       = dmem_addr_q;
    assign rf_wr_en_out        = rf_wr_en_q;
    assign rd_addr_out         = rd_addr_q;
    assign rd_data_out         = rd_data_q;
    assign misaligned_load_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_wb_load_unit.sv
// Self-checking bench for msrv32_wb_load_unit: register-file writes are scored
// against an expected queue filled when each instruction is driven.
module tb_msrv32_wb_load_unit;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        valid_in;
    logic [4:0]  rd_addr_reg_in;
    logic        rf_wr_en_reg_in;
    logic [2:0]  wb_mux_sel_reg_in;
    logic [1:0]  load_size_reg_in;
    logic        load_unsigned_reg_in;
    logic [31:0] iadder_out_reg_in;
    logic [31:0] alu_result_in;
    logic [31:0] imm_reg_in;
    logic [31:0] pc_plus_4_reg_in;
    logic [31:0] csr_data_in;
    logic        dmem_rd_req_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_rdata_in;
    logic        dmem_ack_in;
    logic        stall_out;
    logic        rf_wr_en_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_data_out;
    logic        misaligned_load_out;

    logic [36:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    msrv32_wb_load_unit dut (
        .clk_in(clk_in), .reset_in(reset_in), .valid_in(valid_in),
        .rd_addr_reg_in(rd_addr_reg_in), .rf_wr_en_reg_in(rf_wr_en_reg_in),
        .wb_mux_sel_reg_in(wb_mux_sel_reg_in), .load_size_reg_in(load_size_reg_in),
        .load_unsigned_reg_in(load_unsigned_reg_in), .iadder_out_reg_in(iadder_out_reg_in),
        .alu_result_in(alu_result_in), .imm_reg_in(imm_reg_in),
        .pc_plus_4_reg_in(pc_plus_4_reg_in), .csr_data_in(csr_data_in),
        .dmem_rd_req_out(dmem_rd_req_out), .dmem_addr_out(dmem_addr_out),
        .dmem_rdata_in(dmem_rdata_in), .dmem_ack_in(dmem_ack_in),
        .stall_out(stall_out), .rf_wr_en_out(rf_wr_en_out),
        .rd_addr_out(rd_addr_out), .rd_data_out(rd_data_out),
        .misaligned_load_out(misaligned_load_out)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: every register-file write must match the head of exp_q
    always @(negedge clk_in) begin
        if (!reset_in && rf_wr_en_out) begin
            if (exp_q.size() == 0) begin
                chk("spurious_wr", {27'd0, rd_addr_out, rd_data_out}, 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wb_rd", 64'(rd_addr_out), 64'(e[36:32]));
                chk("wb_data", 64'(rd_data_out), 64'(e[31:0]));
            end
        end
    end

    function automatic logic [31:0] model_wb(input logic [2:0] sel, input logic [31:0] alu,
                                             input logic [31:0] imm, input logic [31:0] iadd,
                                             input logic [31:0] csr, input logic [31:0] pc4);
        case (sel)
            3'b010:  return imm;
            3'b011:  return iadd;
            3'b100:  return csr;
            3'b101:  return pc4;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = (off == 2'd0) ? rdata[7:0] : (off == 2'd1) ? rdata[15:8] :
            (off == 2'd2) ? rdata[23:16] : rdata[31:24];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        if (size == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
        if (size == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
        return rdata;
    endfunction

    task automatic idle_inputs();
        valid_in = 1'b0; rf_wr_en_reg_in = 1'b0; wb_mux_sel_reg_in = 3'd0;
        rd_addr_reg_in = 5'd0; load_size_reg_in = 2'd0; load_unsigned_reg_in = 1'b0;
        dmem_ack_in = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk_in); #1;
    endtask

    // driver: non-load instruction for one cycle, expected write pushed
    task automatic drive_op(input logic [4:0] rd, input logic we, input logic [2:0] sel);
        valid_in = 1'b1; rd_addr_reg_in = rd; rf_wr_en_reg_in = we; wb_mux_sel_reg_in = sel;
        alu_result_in = $urandom; imm_reg_in = $urandom; iadder_out_reg_in = $urandom;
        csr_data_in = $urandom; pc_plus_4_reg_in = $urandom;
        if (we && rd != 5'd0)
            exp_q.push_back({rd, model_wb(sel, alu_result_in, imm_reg_in, iadder_out_reg_in,
                                          csr_data_in, pc_plus_4_reg_in)});
        @(negedge clk_in);
        chk("op_stall", 64'(stall_out), 64'd0);
    endtask

    // driver: aligned load at T, ack in cycle T+k, write-back expected in T+k+1
    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rdata, input int k);
        int stall_cnt;
        valid_in = 1'b1; rd_addr_reg_in = rd; rf_wr_en_reg_in = 1'b1; wb_mux_sel_reg_in = 3'b001;
        load_size_reg_in = size; load_unsigned_reg_in = uns; iadder_out_reg_in = addr;
        if (rd != 5'd0) exp_q.push_back({rd, model_load(rdata, addr[1:0], size, uns)});
        stall_cnt = 0;
        @(negedge clk_in);
        if (stall_out) stall_cnt++;
        chk("ld_req_T", 64'(dmem_rd_req_out), 64'd0);
        for (int i = 1; i <= k; i++) begin
            cyc();
            valid_in = 1'b0;
            if (i == k) begin
                dmem_ack_in = 1'b1; dmem_rdata_in = rdata;
            end else begin
                dmem_rdata_in = $urandom;
            end
            @(negedge clk_in);
            if (stall_out) stall_cnt++;
            chk("ld_req", 64'(dmem_rd_req_out), 64'd1);
            chk("ld_addr", 64'(dmem_addr_out), 64'({addr[31:2], 2'b00}));
        end
        cyc();
        dmem_ack_in = 1'b0; dmem_rdata_in = $urandom;
        @(negedge clk_in);
        if (stall_out) stall_cnt++;
        chk("ld_stall_cycles", 64'(stall_cnt), 64'(k + 1));
        chk("ld_req_done", 64'(dmem_rd_req_out), 64'd0);
        cyc();
    endtask

    task automatic do_misaligned(input logic [31:0] addr, input logic [1:0] size);
        valid_in = 1'b1; rd_addr_reg_in = 5'd9; rf_wr_en_reg_in = 1'b1; wb_mux_sel_reg_in = 3'b001;
        load_size_reg_in = size; iadder_out_reg_in = addr;
        @(negedge clk_in);
        chk("mis_stall", 64'(stall_out), 64'd0);
        cyc();
        idle_inputs();
        @(negedge clk_in);
        chk("mis_pulse", 64'(misaligned_load_out), 64'd1);
        chk("mis_req", 64'(dmem_rd_req_out), 64'd0);
        cyc();
        @(negedge clk_in);
        chk("mis_pulse_end", 64'(misaligned_load_out), 64'd0);
        cyc();
    endtask

    initial begin
        reset_in = 1'b1;
        idle_inputs();
        alu_result_in = '0; imm_reg_in = '0; iadder_out_reg_in = '0;
        csr_data_in = '0; pc_plus_4_reg_in = '0; dmem_rdata_in = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_outs", {dmem_rd_req_out, dmem_addr_out, rf_wr_en_out, rd_addr_out,
                         rd_data_out, misaligned_load_out, stall_out}, 64'd0);
        cyc();
        reset_in = 1'b0;
        cyc();

        // ALU write-back: rd=5, 0x1234
        valid_in = 1'b1; rd_addr_reg_in = 5'd5; rf_wr_en_reg_in = 1'b1; wb_mux_sel_reg_in = 3'b000;
        alu_result_in = 32'h0000_1234;
        exp_q.push_back({5'd5, 32'h0000_1234});
        cyc();
        idle_inputs();
        @(negedge clk_in);
        chk("alu_wr_T1", 64'(rf_wr_en_out), 64'd1);
        cyc();
        @(negedge clk_in);
        chk("alu_wr_T2", 64'(rf_wr_en_out), 64'd0);
        cyc();

        // back-to-back random non-loads, every select code except load
        for (int i = 0; i < 24; i++) begin
            logic [2:0] sel;
            do sel = 3'($urandom_range(0, 7)); while (sel == 3'b001);
            drive_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), sel);
            cyc();
        end
        idle_inputs();
        cyc();

        // ack outside WAIT is ignored
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'hDEAD_BEEF;
        cyc();
        dmem_ack_in = 1'b0;
        @(negedge clk_in);
        chk("stray_ack_req", 64'(dmem_rd_req_out), 64'd0);
        cyc();

        do_load(5'd7, 32'h0000_2003, 2'b00, 1'b0, 32'h80AA_BBCC, 3);
        do_load(5'd8, 32'h0000_3002, 2'b01, 1'b1, 32'hCCCC_DDDD, 1);
        do_misaligned(32'h0000_0101, 2'b10);
        do_misaligned(32'h0000_3001, 2'b01);
        do_load(5'd0, 32'h0000_4000, 2'b10, 1'b0, 32'h1234_5678, 2);

        for (int i = 0; i < 10; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
            do_load(5'($urandom_range(1, 31)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(1, 4));
        end

        // reset mid-load, then a late ack must not write
        valid_in = 1'b1; rd_addr_reg_in = 5'd12; rf_wr_en_reg_in = 1'b1; wb_mux_sel_reg_in = 3'b001;
        load_size_reg_in = 2'b10; iadder_out_reg_in = 32'h0000_5000;
        cyc();
        idle_inputs();
        @(negedge clk_in);
        chk("mid_req", 64'(dmem_rd_req_out), 64'd1);
        #2 reset_in = 1'b1;
        #1;
        chk("mid_rst_outs", {dmem_rd_req_out, dmem_addr_out, rf_wr_en_out, rd_addr_out,
                             rd_data_out, misaligned_load_out, stall_out}, 64'd0);
        cyc();
        reset_in = 1'b0;
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'hAAAA_5555;
        cyc();
        dmem_ack_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_wr", 64'(rf_wr_en_out), 64'd0);
        chk("post_rst_stall", 64'(stall_out), 64'd0);
        cyc();

        // state is IDLE again: a plain op goes straight through
        drive_op(5'd3, 1'b1, 3'b010);
        cyc();
        idle_inputs();
        repeat (2) cyc();
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
